// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multicycle controller
package mc_pkg;

    typedef enum logic [4:0] {
        S_RESET    = 5'd0,
        S_FETCH    = 5'd1,
        S_IWAIT    = 5'd2,
        S_DECODE   = 5'd3,
        S_EXEC_R   = 5'd4,
        S_WB_R     = 5'd5,
        S_EXEC_I   = 5'd6,
        S_WB_I     = 5'd7,
        S_LUI      = 5'd8,
        S_MEM_ADDR = 5'd9,
        S_MEM_RD   = 5'd10,
        S_DWAIT    = 5'd11,
        S_MEM_WB   = 5'd12,
        S_MEM_WR   = 5'd13,
        S_BRANCH   = 5'd14,
        S_JUMP     = 5'd15,
        S_JAL      = 5'd16,
        S_JR       = 5'd17,
        S_MD_START = 5'd18,
        S_MD_BUSY  = 5'd19,
        S_MFHILO   = 5'd20,
        S_EXC      = 5'd21,
        S_MD_WB    = 5'd22
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLE   = 6'h06;
    localparam logic [5:0] OP_BGT   = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_SLT = 3'd3;

    localparam logic [2:0] IORD_PC     = 3'd0;
    localparam logic [2:0] IORD_ALUOUT = 3'd1;

    localparam logic [1:0] SRCA_PC  = 2'd0;
    localparam logic [1:0] SRCA_REG = 2'd1;

    localparam logic [2:0] SRCB_REG  = 3'd0;
    localparam logic [2:0] SRCB_FOUR = 3'd1;
    localparam logic [2:0] SRCB_IMM  = 3'd2;
    localparam logic [2:0] SRCB_BOFF = 3'd3;

    localparam logic [2:0] PCSRC_ALU    = 3'd0;
    localparam logic [2:0] PCSRC_ALUOUT = 3'd1;
    localparam logic [2:0] PCSRC_JUMP   = 3'd2;
    localparam logic [2:0] PCSRC_REG    = 3'd3;
    localparam logic [2:0] PCSRC_VEC    = 3'd4;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [2:0] M2R_ALU = 3'd0;
    localparam logic [2:0] M2R_MEM = 3'd1;
    localparam logic [2:0] M2R_LUI = 3'd2;
    localparam logic [2:0] M2R_PC  = 3'd3;
    localparam logic [2:0] M2R_HI  = 3'd4;
    localparam logic [2:0] M2R_LO  = 3'd5;

    localparam logic [1:0] CAUSE_INV  = 2'd0;
    localparam logic [1:0] CAUSE_OVF  = 2'd1;
    localparam logic [1:0] CAUSE_DIVZ = 2'd2;

    function automatic logic [2:0] alu_for_funct(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_wait_cnt.sv
// rtl/mc_wait_cnt.sv - memory wait counter (load, decrement, zero flag)
module mc_wait_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [2:0] cnt;

    // load on wait-state entry, then count down and park at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 3'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != 3'd0)) begin
            cnt <= cnt - 3'd1;
        end
    end

    assign zero = (cnt == 3'd0);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle CPU control FSM; exceptions enabled by MULTICYCLE_CTRL_EXC_EN
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int MEM_WAIT = 1,
    parameter int ST_W     = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic            ET,
    input  logic            GT,
    input  logic            LT,
    input  logic            overflow,
    input  logic            div_zero,
    input  logic            md_done,
    output logic [ST_W-1:0] state_out,
    output logic            pc_write,
    output logic            ir_write,
    output logic            mem_write,
    output logic            reg_write,
    output logic            epc_write,
    output logic            hilo_write,
    output logic            md_start,
    output logic            md_sel,
    output logic [2:0]      ior_d,
    output logic [1:0]      reg_dst,
    output logic [2:0]      mem_to_reg,
    output logic [1:0]      alu_src_a,
    output logic [2:0]      alu_src_b,
    output logic [2:0]      alu_op,
    output logic [2:0]      pc_source,
    output logic [1:0]      exc_cause
);

`ifdef MULTICYCLE_CTRL_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT - 1);
    localparam state_t     INV_NEXT  = EXC_EN ? S_EXC : S_FETCH;

    state_t     state, state_nxt;
    logic [5:0] op_q, fn_q;
    logic       md_pend;
    logic [1:0] cause_nxt;
    logic       wait_zero, wait_load, wait_dec;
    logic       br_taken;

    assign wait_load = ((state_nxt == S_IWAIT) && (state != S_IWAIT)) ||
                       ((state_nxt == S_DWAIT) && (state != S_DWAIT));
    assign wait_dec  = (state == S_IWAIT) || (state == S_DWAIT);

    mc_wait_cnt u_wait (
        .clk      (clk),
        .reset    (reset),
        .load     (wait_load),
        .load_val (WAIT_LOAD),
        .dec      (wait_dec),
        .zero     (wait_zero)
    );

    // state register; IR fields captured in DECODE so later outputs stay state-driven
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_RESET;
            op_q    <= 6'd0;
            fn_q    <= 6'd0;
            md_pend <= 1'b0;
        end else begin
            state   <= state_nxt;
            md_pend <= (state == S_MD_START) && md_done;
            if (state == S_DECODE) begin
                op_q <= opcode;
                fn_q <= funct;
            end
        end
    end

    // next-state logic and the cause to record when entering EXC
    always_comb begin
        state_nxt = state;
        cause_nxt = CAUSE_INV;
        case (state)
            S_RESET:    state_nxt = S_FETCH;
            S_FETCH:    state_nxt = S_IWAIT;
            S_IWAIT:    if (wait_zero) state_nxt = S_DECODE;
            S_DECODE: begin
                state_nxt = INV_NEXT;
                case (opcode)
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD, FN_SUB, FN_AND, FN_SLT: state_nxt = S_EXEC_R;
                            FN_JR:                          state_nxt = S_JR;
                            FN_MULT, FN_DIV:                state_nxt = S_MD_START;
                            FN_MFHI, FN_MFLO:               state_nxt = S_MFHILO;
                            default:                        state_nxt = INV_NEXT;
                        endcase
                    end
                    OP_ADDI:                        state_nxt = S_EXEC_I;
                    OP_BEQ, OP_BNE, OP_BLE, OP_BGT: state_nxt = S_BRANCH;
                    OP_LW, OP_SW:                   state_nxt = S_MEM_ADDR;
                    OP_LUI:                         state_nxt = S_LUI;
                    OP_J:                           state_nxt = S_JUMP;
                    OP_JAL:                         state_nxt = S_JAL;
                    default:                        state_nxt = INV_NEXT;
                endcase
            end
            S_EXEC_R: begin
                cause_nxt = CAUSE_OVF;
                state_nxt = (EXC_EN && overflow && ((fn_q == FN_ADD) || (fn_q == FN_SUB)))
                            ? S_EXC : S_WB_R;
            end
            S_EXEC_I: begin
                cause_nxt = CAUSE_OVF;
                state_nxt = (EXC_EN && overflow) ? S_EXC : S_WB_I;
            end
            S_MEM_ADDR: state_nxt = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_nxt = S_DWAIT;
            S_DWAIT:    if (wait_zero) state_nxt = S_MEM_WB;
            S_MD_START: begin
                cause_nxt = CAUSE_DIVZ;
                state_nxt = (EXC_EN && div_zero && (fn_q == FN_DIV)) ? S_EXC : S_MD_BUSY;
            end
            S_MD_BUSY:  if (md_done || md_pend) state_nxt = S_MD_WB;
            S_WB_R, S_WB_I, S_LUI, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP,
            S_JAL, S_JR, S_MFHILO, S_MD_WB, S_EXC:
                        state_nxt = S_FETCH;
            default:    state_nxt = S_RESET;
        endcase
    end

`ifdef MULTICYCLE_CTRL_EXC_EN
    logic [1:0] cause_q;

    // cause is captured only on EXC entry and held until the next one
    always_ff @(posedge clk) begin
        if (reset) begin
            cause_q <= CAUSE_INV;
        end else if ((state_nxt == S_EXC) && (state != S_EXC)) begin
            cause_q <= cause_nxt;
        end
    end

    assign exc_cause = cause_q;
`else
    logic unused_cause;
    assign unused_cause = ^cause_nxt;
    assign exc_cause    = 2'b00;
`endif

    assign epc_write = EXC_EN && (state == S_EXC);
    assign state_out = ST_W'(state);

    // branch decision uses the compare flags the ALU produces during BRANCH
    always_comb begin
        case (op_q)
            OP_BEQ:  br_taken = ET;
            OP_BNE:  br_taken = !ET;
            OP_BLE:  br_taken = LT || ET;
            OP_BGT:  br_taken = GT;
            default: br_taken = 1'b0;
        endcase
    end

    // per-state datapath controls; every default is the all-zero RESET encoding
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        hilo_write = 1'b0;
        md_start   = 1'b0;
        md_sel     = 1'b0;
        ior_d      = IORD_PC;
        reg_dst    = REGDST_RT;
        mem_to_reg = M2R_ALU;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        pc_source  = PCSRC_ALU;
        case (state)
            S_FETCH:    alu_src_b = SRCB_FOUR;
            S_IWAIT: begin
                alu_src_b = SRCB_FOUR;
                ir_write  = wait_zero;
                pc_write  = wait_zero;
            end
            S_DECODE:   alu_src_b = SRCB_BOFF;
            S_EXEC_R: begin
                alu_src_a = SRCA_REG;
                alu_op    = alu_for_funct(fn_q);
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = REGDST_RD;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                alu_src_a = SRCA_REG;
                alu_src_b = SRCB_IMM;
            end
            S_WB_I:     reg_write = 1'b1;
            S_LUI: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_LUI;
            end
            S_MEM_RD, S_DWAIT: ior_d = IORD_ALUOUT;
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MEM;
            end
            S_MEM_WR: begin
                ior_d     = IORD_ALUOUT;
                mem_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = SRCA_REG;
                alu_op    = ALU_SUB;
                pc_source = PCSRC_ALUOUT;
                pc_write  = br_taken;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                reg_write  = 1'b1;
                reg_dst    = REGDST_RA;
                mem_to_reg = M2R_PC;
            end
            S_JR: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_REG;
            end
            S_MD_START: begin
                md_start  = 1'b1;
                md_sel    = (fn_q == FN_DIV);
                alu_src_a = SRCA_REG;
            end
            S_MD_BUSY:  md_sel = (fn_q == FN_DIV);
            S_MD_WB: begin
                md_sel     = (fn_q == FN_DIV);
                hilo_write = 1'b1;
            end
            S_MFHILO: begin
                reg_write  = 1'b1;
                reg_dst    = REGDST_RD;
                mem_to_reg = (fn_q == FN_MFHI) ? M2R_HI : M2R_LO;
            end
            S_EXC: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_VEC;
            end
            default: ;
        endcase
    end

endmodule
